// File: rtl/icap_wb_loader.sv
// Wishbone master that streams framed 36-bit FIFO words into the ICAP Wishbone slave,
// one single-beat write per word, with timeout, abort and a saturating acked-word count.
module icap_wb_loader #(
   parameter int TIMEOUT    = 255,
   parameter int SWAP_BYTES = 1,
   parameter int CNT_W      = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [35:0]      data_i,
   input  logic             src_rdy_i,
   output logic             dst_rdy_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [31:0]      dat_o,
   input  logic             ack_i,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SOF,
      WAIT_DATA,
      WB_WRITE,
      DONE,
      ERROR
   } state_t;

   localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [31:0] word_q;
   logic        eof_q;
   logic [15:0] tmr;
   logic [31:0] swapped;
   logic        load_word;
   logic        clear_cnt;
   logic        inc_cnt;
   logic        unused_bits;

   assign unused_bits = &{1'b0, data_i[35:34]};

   assign swapped = (SWAP_BYTES != 0) ?
                    {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]} : data_i[31:0];

   // Next state and state-decoded outputs; abort overrides every transition.
   always_comb begin
      state_next = state;
      dst_rdy_o  = 1'b0;
      cyc_o      = 1'b0;
      stb_o      = 1'b0;
      we_o       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      load_word  = 1'b0;
      clear_cnt  = 1'b0;
      inc_cnt    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = WAIT_SOF;
               clear_cnt  = 1'b1;
            end
         end
         WAIT_SOF: begin
            dst_rdy_o = 1'b1;
            busy      = 1'b1;
            if (src_rdy_i && data_i[32]) begin
               state_next = WB_WRITE;
               load_word  = 1'b1;
            end
         end
         WAIT_DATA: begin
            dst_rdy_o = 1'b1;
            busy      = 1'b1;
            if (src_rdy_i) begin
               state_next = WB_WRITE;
               load_word  = 1'b1;
            end
         end
         WB_WRITE: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            we_o  = 1'b1;
            busy  = 1'b1;
            if (ack_i) begin
               state_next = eof_q ? DONE : WAIT_DATA;
               inc_cnt    = 1'b1;
            end else if (tmr == TMR_LAST) begin
               state_next = ERROR;
            end
         end
         DONE, ERROR: begin
            done  = (state == DONE);
            error = (state == ERROR);
            if (start) begin
               state_next = WAIT_SOF;
               clear_cnt  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
         load_word  = 1'b0;
         clear_cnt  = 1'b0;
         inc_cnt    = 1'b0;
      end
   end

   // Timer restarts on every entry to the write so each word gets the full TIMEOUT window.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         word_q     <= '0;
         eof_q      <= 1'b0;
         tmr        <= '0;
         word_count <= '0;
      end else begin
         state <= state_next;
         if (load_word) begin
            word_q <= swapped;
            eof_q  <= data_i[33];
            tmr    <= '0;
         end else if (state == WB_WRITE) begin
            tmr <= tmr + 16'd1;
         end
         if (clear_cnt) begin
            word_count <= '0;
         end else if (inc_cnt && (word_count != {CNT_W{1'b1}})) begin
            word_count <= word_count + 1'b1;
         end
      end
   end

   assign dat_o = word_q;

endmodule

// File: tb/tb_icap_wb_loader.sv
// Bench for icap_wb_loader: directed loads against a transaction model of which words must be
// written, plus per-cycle Wishbone protocol and word-count checks.
module tb_icap_wb_loader;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [35:0] data_i;
   logic        src_rdy_i;
   logic        dst_rdy_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] dat_o;
   logic        ack_i;
   logic        busy;
   logic        done;
   logic        error;
   logic [23:0] word_count;

   icap_wb_loader #(.TIMEOUT(TO), .SWAP_BYTES(1), .CNT_W(24)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .dat_o(dat_o), .ack_i(ack_i),
      .busy(busy), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [35:0] feed_q[$];
   logic [31:0] exp_q[$];
   bit          in_load = 0;
   int          model_count = 0;
   bit          cnt_chk = 0;
   bit          mon_en = 0;
   bit          flush_req = 0;
   bit          pend_acc = 0;
   bit          prev_hs = 0;
   int          ack_delay = 1;
   int          stb_run = 0;
   int          last_run = 0;
   int          hs_total = 0;
   logic [31:0] last_dat = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // A word is written if it opens a load (sof) or arrives inside one; eof closes the load.
   task automatic model_accept(input logic [35:0] w);
      if (in_load || w[32]) begin
         exp_q.push_back(swap32(w[31:0]));
         in_load = !w[33];
      end
   endtask

   // Feeder, slave and checker share one negedge process so their ordering is fixed.
   initial begin
      src_rdy_i = 1'b0;
      data_i    = '0;
      ack_i     = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (flush_req) begin
               feed_q.delete();
               exp_q.delete();
               src_rdy_i = 1'b0;
               pend_acc  = 0;
               in_load   = 0;
               flush_req = 0;
            end
            if (pend_acc) begin
               void'(feed_q.pop_front());
               src_rdy_i = 1'b0;
               pend_acc  = 0;
            end
            if (!src_rdy_i && feed_q.size() > 0) begin
               data_i    = feed_q[0];
               src_rdy_i = 1'b1;
            end
            if (stb_o) begin
               stb_run++;
            end else begin
               if (stb_run > 0) last_run = stb_run;
               stb_run = 0;
            end
            ack_i = stb_o && (ack_delay >= 0) && (stb_run == ack_delay + 1) && !abort;

            checkOutput("cyc_eq_stb", {31'b0, cyc_o}, {31'b0, stb_o});
            checkOutput("we_eq_stb", {31'b0, we_o}, {31'b0, stb_o});
            if (prev_hs) checkOutput("stb_after_ack", {31'b0, stb_o}, 32'd0);
            if (stb_o) begin
               checkOutput("rdy_during_stb", {31'b0, dst_rdy_o}, 32'd0);
               checkOutput("stb_run_bound", {31'b0, stb_run <= TO}, 32'd1);
            end
            if (cnt_chk) checkOutput("word_count", {8'b0, word_count}, model_count);

            prev_hs = stb_o && ack_i && !abort;
            if (prev_hs) begin
               checkOutput("write_expected", {31'b0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) checkOutput("wb_data", dat_o, exp_q.pop_front());
               last_dat = dat_o;
               model_count++;
               hs_total++;
            end
            pend_acc = src_rdy_i && dst_rdy_o && !abort;
            if (pend_acc) model_accept(data_i);
         end
      end
   end

   task automatic start_load();
      @(posedge clk); #1;
      cnt_chk = 0;
      start   = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      model_count = 0;
      cnt_chk     = 1;
   endtask

   task automatic abort_pulse();
      @(posedge clk); #1;
      abort     = 1'b1;
      flush_req = 1;
      @(posedge clk); #1;
      abort = 1'b0;
   endtask

   task automatic wait_end(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc && !(done || error); i++) begin
         @(negedge clk); #2;
      end
      checkOutput(name, {31'b0, done || error}, 32'd1);
   endtask

   task automatic applyStimulus(input logic [35:0] w);
      feed_q.push_back(w);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_outputs", {26'b0, dst_rdy_o, cyc_o, stb_o, we_o, busy, done | error}, 32'd0);
      checkOutput("rst_dat", dat_o, 32'd0);
      checkOutput("rst_count", {8'b0, word_count}, 32'd0);
      reset  = 1'b0;
      mon_en = 1;
      cnt_chk = 1;

      // start and abort together: abort wins, stays idle
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; flush_req = 1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk); #2;
      checkOutput("abort_wins_busy", {31'b0, busy}, 32'd0);

      // 3-word load, slave acks 2 cycles after stb
      ack_delay = 2; hs_total = 0;
      applyStimulus({4'b0001, 32'h11111111});
      applyStimulus({4'b0000, 32'h22222222});
      applyStimulus({4'b0010, 32'h12345678});
      start_load();
      wait_end("t1_finish", 60);
      checkOutput("t1_done", {30'b0, done, error}, 32'd2);
      checkOutput("t1_count", {8'b0, word_count}, 32'd3);
      checkOutput("t1_writes", hs_total, 32'd3);
      checkOutput("t1_last_dat", last_dat, 32'h78563412);

      // single sof|eof word with byte swap, started from DONE; bits 35:34 ignored
      ack_delay = 1; hs_total = 0;
      applyStimulus(36'hB_AA995566);
      start_load();
      wait_end("t2_finish", 40);
      checkOutput("t2_done", {31'b0, done}, 32'd1);
      checkOutput("t2_dat", last_dat, 32'h665599AA);
      checkOutput("t2_count", {8'b0, word_count}, 32'd1);

      // words before sof are dropped
      hs_total = 0;
      applyStimulus(36'h0_DEADBEEF);
      applyStimulus(36'h0_CAFEF00D);
      applyStimulus(36'h3_01020304);
      start_load();
      wait_end("t3_finish", 40);
      checkOutput("t3_writes", hs_total, 32'd1);
      checkOutput("t3_dat", last_dat, 32'h04030201);
      checkOutput("t3_count", {8'b0, word_count}, 32'd1);

      // slave never acks: stb high exactly TO cycles, then error
      ack_delay = -1; hs_total = 0;
      applyStimulus(36'h3_0000ABCD);
      start_load();
      wait_end("t4_finish", 40);
      checkOutput("t4_error", {30'b0, error, done}, 32'd2);
      checkOutput("t4_cyc", {31'b0, cyc_o}, 32'd0);
      checkOutput("t4_stb_run", last_run, 32'd8);
      checkOutput("t4_count", {8'b0, word_count}, 32'd0);
      flush_req = 1;
      @(negedge clk); #2;

      // abort during the second write's strobe
      ack_delay = 2; hs_total = 0;
      applyStimulus({4'b0001, 32'h0A0B0C0D});
      applyStimulus({4'b0000, 32'h11223344});
      applyStimulus({4'b0010, 32'h55667788});
      start_load();
      for (int i = 0; i < 40 && !(hs_total == 1 && stb_o && !ack_i); i++) begin
         @(negedge clk); #2;
      end
      checkOutput("t5_reach_w2", {31'b0, hs_total == 1 && stb_o}, 32'd1);
      abort_pulse();
      @(negedge clk); #2;
      checkOutput("t5_idle", {29'b0, busy, stb_o, cyc_o}, 32'd0);
      checkOutput("t5_count", {8'b0, word_count}, 32'd1);
      checkOutput("t5_writes", hs_total, 32'd1);
      start_load();
      @(negedge clk); #2;
      checkOutput("t5_cleared", {8'b0, word_count}, 32'd0);
      checkOutput("t5_busy", {31'b0, busy}, 32'd1);
      abort_pulse();

      // ack every cycle, 4-word stream
      ack_delay = 0; hs_total = 0;
      applyStimulus({4'b0001, 32'hA0A1A2A3});
      applyStimulus({4'b0000, 32'hB0B1B2B3});
      applyStimulus({4'b0001, 32'hC0C1C2C3});
      applyStimulus({4'b0010, 32'hD0D1D2D3});
      start_load();
      wait_end("t6_finish", 60);
      checkOutput("t6_done", {31'b0, done}, 32'd1);
      checkOutput("t6_count", {8'b0, word_count}, 32'd4);
      checkOutput("t6_writes", hs_total, 32'd4);
      checkOutput("t6_last_dat", last_dat, 32'hD3D2D1D0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
